// File: rtl/hdmi_timing_scheduler.sv
// hdmi_timing_scheduler: raster counters, stream start/stop sequencing and
// frame-aligned timing-mode changes for the HDMI sync/data-enable stage.
module hdmi_timing_scheduler #(
    parameter int HLEN = 12,
    parameter int VLEN = 11,
    parameter logic [4*HLEN-1:0] DEF_H = {HLEN'(640), HLEN'(16), HLEN'(96), HLEN'(48)},
    parameter logic [4*VLEN-1:0] DEF_V = {VLEN'(480), VLEN'(10), VLEN'(2), VLEN'(33)}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_enable,
    input  logic              i_cfg_valid,
    output logic              o_cfg_ready,
    input  logic [4*HLEN-1:0] i_cfg_h,
    input  logic [4*VLEN-1:0] i_cfg_v,
    output logic              o_cfg_err,
    output logic [4*HLEN-1:0] o_act_h,
    output logic [4*VLEN-1:0] o_act_v,
    output logic [HLEN-1:0]   o_hcount,
    output logic [VLEN-1:0]   o_vcount,
    output logic              o_pixel_inc,
    output logic              o_line_start,
    output logic              o_frame_start,
    output logic              o_running
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [4*HLEN-1:0] pend_h;
    logic [4*VLEN-1:0] pend_v;
    logic [HLEN+1:0]   ht, cfg_ht;
    logic [VLEN+1:0]   vt, cfg_vt;
    logic [HLEN-1:0]   h_nxt;
    logic [VLEN-1:0]   v_nxt;
    logic              h_end, v_end, frame_end, cfg_ok, accept, apply;

    function automatic logic [HLEN+1:0] h_total(input logic [4*HLEN-1:0] t);
        return (HLEN+2)'(t[4*HLEN-1 -: HLEN]) + (HLEN+2)'(t[3*HLEN-1 -: HLEN])
             + (HLEN+2)'(t[2*HLEN-1 -: HLEN]) + (HLEN+2)'(t[HLEN-1:0]);
    endfunction

    function automatic logic [VLEN+1:0] v_total(input logic [4*VLEN-1:0] t);
        return (VLEN+2)'(t[4*VLEN-1 -: VLEN]) + (VLEN+2)'(t[3*VLEN-1 -: VLEN])
             + (VLEN+2)'(t[2*VLEN-1 -: VLEN]) + (VLEN+2)'(t[VLEN-1:0]);
    endfunction

    always_comb begin
        ht        = h_total(o_act_h);
        vt        = v_total(o_act_v);
        cfg_ht    = h_total(i_cfg_h);
        cfg_vt    = v_total(i_cfg_v);
        h_end     = {2'b00, o_hcount} == ht - (HLEN+2)'(1);
        v_end     = {2'b00, o_vcount} == vt - (VLEN+2)'(1);
        frame_end = o_running && h_end && v_end;
        h_nxt     = (o_running && !h_end) ? o_hcount + HLEN'(1) : '0;
        v_nxt     = !o_running ? '0 : !h_end ? o_vcount : v_end ? '0 : o_vcount + VLEN'(1);
        cfg_ok    = (|i_cfg_h[4*HLEN-1 -: HLEN]) && (|i_cfg_h[2*HLEN-1 -: HLEN])
                 && (|i_cfg_v[4*VLEN-1 -: VLEN]) && (|i_cfg_v[2*VLEN-1 -: VLEN])
                 && (cfg_ht <= ((HLEN+2)'(1) << HLEN)) && (cfg_vt <= ((VLEN+2)'(1) << VLEN));
        accept    = i_cfg_valid && o_cfg_ready;
        // pending is only ever swapped in while no frame is in flight or on its last pixel
        apply     = !o_cfg_ready && (state == IDLE || frame_end);
        state_nxt = i_enable ? RUN : (state == IDLE || frame_end) ? IDLE : DRAIN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            o_hcount      <= '0;
            o_vcount      <= '0;
            o_pixel_inc   <= 1'b0;
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
            o_running     <= 1'b0;
            o_cfg_ready   <= 1'b1;
            o_cfg_err     <= 1'b0;
            o_act_h       <= DEF_H;
            o_act_v       <= DEF_V;
            pend_h        <= '0;
            pend_v        <= '0;
        end else begin
            state         <= state_nxt;
            o_running     <= state_nxt != IDLE;
            o_pixel_inc   <= state_nxt != IDLE;
            o_hcount      <= h_nxt;
            o_vcount      <= v_nxt;
            o_line_start  <= state_nxt != IDLE && h_nxt == '0;
            o_frame_start <= state_nxt != IDLE && h_nxt == '0 && v_nxt == '0;
            if (accept) begin
                o_cfg_err <= !cfg_ok;
                if (cfg_ok) begin
                    pend_h      <= i_cfg_h;
                    pend_v      <= i_cfg_v;
                    o_cfg_ready <= 1'b0;
                end
            end
            if (apply) begin
                o_act_h     <= pend_h;
                o_act_v     <= pend_v;
                o_cfg_ready <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_hdmi_timing_scheduler.sv
// tb_hdmi_timing_scheduler: checks the scheduler against a frame-level model
// that tracks a linear pixel index and derives positions by division.
module tb_hdmi_timing_scheduler;
    localparam int HLEN = 12;
    localparam int VLEN = 11;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b0;
    logic              cfg_valid = 1'b0;
    logic [4*HLEN-1:0] cfg_h = '0;
    logic [4*VLEN-1:0] cfg_v = '0;
    logic              cfg_ready, cfg_err, pixel_inc, line_start, frame_start, running;
    logic [4*HLEN-1:0] act_h;
    logic [4*VLEN-1:0] act_v;
    logic [HLEN-1:0]   hcount;
    logic [VLEN-1:0]   vcount;

    hdmi_timing_scheduler dut (
        .clk(clk), .rst(rst), .i_enable(enable), .i_cfg_valid(cfg_valid), .o_cfg_ready(cfg_ready),
        .i_cfg_h(cfg_h), .i_cfg_v(cfg_v), .o_cfg_err(cfg_err), .o_act_h(act_h), .o_act_v(act_v),
        .o_hcount(hcount), .o_vcount(vcount), .o_pixel_inc(pixel_inc), .o_line_start(line_start),
        .o_frame_start(frame_start), .o_running(running)
    );

    always #5 clk = ~clk;

    logic [26:0] dut_run;
    logic [93:0] dut_cfg;
    assign dut_run = {hcount, vcount, pixel_inc, line_start, frame_start, running};
    assign dut_cfg = {cfg_ready, cfg_err, act_h, act_v};

    int n_chk = 0;
    int n_fail = 0;
    int mh[4], mv[4], ph[4], pv[4], th[4], tv[4];
    bit m_run, m_pend, m_err;
    int p;

    function automatic int tot(input int a[4]);
        return a[0] + a[1] + a[2] + a[3];
    endfunction

    function automatic logic [4*HLEN-1:0] pk_h(input int a[4]);
        return {HLEN'(a[0]), HLEN'(a[1]), HLEN'(a[2]), HLEN'(a[3])};
    endfunction

    function automatic logic [4*VLEN-1:0] pk_v(input int a[4]);
        return {VLEN'(a[0]), VLEN'(a[1]), VLEN'(a[2]), VLEN'(a[3])};
    endfunction

    function automatic int cur_h();
        return m_run ? p % tot(mh) : 0;
    endfunction

    function automatic int cur_v();
        return m_run ? p / tot(mh) : 0;
    endfunction

    function automatic logic [26:0] exp_run();
        return {HLEN'(cur_h()), VLEN'(cur_v()), m_run, m_run && cur_h() == 0, m_run && p == 0, m_run};
    endfunction

    function automatic logic [93:0] exp_cfg();
        return {!m_pend, m_err, pk_h(mh), pk_v(mv)};
    endfunction

    task automatic model_reset();
        mh = '{640, 16, 96, 48};
        mv = '{480, 10, 2, 33};
        m_run = 0;
        m_pend = 0;
        m_err = 0;
        p = 0;
    endtask

    task automatic model_step();
        int ch[4], cv[4];
        bit fend, acc, app;
        fend = m_run && p == tot(mh) * tot(mv) - 1;
        acc = cfg_valid && !m_pend;
        app = m_pend && (!m_run || fend);
        p = (m_run && !fend) ? p + 1 : 0;
        m_run = enable || (m_run && !fend);
        if (app) begin
            mh = ph;
            mv = pv;
            m_pend = 0;
        end
        if (acc) begin
            for (int k = 0; k < 4; k++) begin
                ch[k] = int'(cfg_h[(3-k)*HLEN +: HLEN]);
                cv[k] = int'(cfg_v[(3-k)*VLEN +: VLEN]);
            end
            if (ch[0] == 0 || ch[2] == 0 || cv[0] == 0 || cv[2] == 0 || tot(ch) > 4096 || tot(cv) > 2048)
                m_err = 1;
            else begin
                ph = ch;
                pv = cv;
                m_pend = 1;
                m_err = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b0;
        cfg_valid = 1'b0;
        #1 model_reset();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_chk++;
        if (dut_run !== exp_run()) begin n_fail++; $display("FAIL reset_run got %h exp %h", dut_run, exp_run()); end
        n_chk++;
        if (dut_cfg !== exp_cfg()) begin n_fail++; $display("FAIL reset_cfg got %h exp %h", dut_cfg, exp_cfg()); end
        n_chk++;
        if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", cfg_ready); end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_chk++;
            if (dut_run !== exp_run()) begin n_fail++; $display("FAIL idle_run got %h exp %h", dut_run, exp_run()); end
        end
    endtask

    task automatic test_default_run();
        enable = 1'b1;
        for (int i = 0; i < 1700; i++) begin
            tick();
            n_chk++;
            if (dut_run !== exp_run()) begin n_fail++; $display("FAIL default_run got %h exp %h", dut_run, exp_run()); end
            n_chk++;
            if (dut_cfg !== exp_cfg()) begin n_fail++; $display("FAIL default_cfg got %h exp %h", dut_cfg, exp_cfg()); end
        end
    endtask

    task automatic test_small_mode();
        int fs = 0, ls = 0;
        do_reset();
        th = '{4, 1, 2, 1};
        tv = '{2, 1, 1, 1};
        cfg_h = pk_h(th);
        cfg_v = pk_v(tv);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        n_chk++;
        if (dut_cfg !== exp_cfg()) begin n_fail++; $display("FAIL small_accept got %h exp %h", dut_cfg, exp_cfg()); end
        tick();
        n_chk++;
        if (act_h !== {12'd4, 12'd1, 12'd2, 12'd1} || cfg_ready !== 1'b1) begin
            n_fail++; $display("FAIL small_apply got %h/%b exp 004001002001/1", act_h, cfg_ready);
        end
        enable = 1'b1;
        for (int i = 0; i < 130; i++) begin
            tick();
            fs += int'(frame_start);
            ls += int'(line_start);
            n_chk++;
            if (dut_run !== exp_run()) begin n_fail++; $display("FAIL small_run got %h exp %h", dut_run, exp_run()); end
        end
        n_chk++;
        if (fs !== 4 || ls !== 17) begin n_fail++; $display("FAIL small_strobes got fs=%0d ls=%0d exp 4/17", fs, ls); end
    endtask

    task automatic test_mode_change();
        for (int i = 0; i < 100 && !(cur_h() == 3 && cur_v() == 2); i++) tick();
        n_chk++;
        if (!(cur_h() == 3 && cur_v() == 2)) begin n_fail++; $display("FAIL mode_wait got h=%0d v=%0d exp 3/2", cur_h(), cur_v()); end
        th = '{6, 1, 1, 2};
        tv = '{2, 1, 1, 1};
        cfg_h = pk_h(th);
        cfg_v = pk_v(tv);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        n_chk++;
        if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL mode_ready got %b exp 0", cfg_ready); end
        for (int i = 0; i < 150; i++) begin
            tick();
            n_chk++;
            if (dut_run !== exp_run()) begin n_fail++; $display("FAIL mode_run got %h exp %h", dut_run, exp_run()); end
            n_chk++;
            if (dut_cfg !== exp_cfg()) begin n_fail++; $display("FAIL mode_cfg got %h exp %h", dut_cfg, exp_cfg()); end
        end
    endtask

    task automatic test_cfg_error();
        int bad_h[3][4];
        int bad_v[3][4];
        bad_h = '{'{0, 1, 2, 1}, '{4095, 1, 1, 0}, '{4, 1, 2, 1}};
        bad_v = '{'{2, 1, 1, 1}, '{2, 1, 1, 1}, '{2047, 1, 1, 0}};
        for (int c = 0; c < 3; c++) begin
            th = bad_h[c];
            tv = bad_v[c];
            cfg_h = pk_h(th);
            cfg_v = pk_v(tv);
            cfg_valid = 1'b1;
            tick();
            n_chk++;
            if (cfg_err !== 1'b1 || cfg_ready !== 1'b1) begin
                n_fail++; $display("FAIL cfg_reject%0d got err=%b rdy=%b exp 1/1", c, cfg_err, cfg_ready);
            end
            n_chk++;
            if (dut_cfg !== exp_cfg()) begin n_fail++; $display("FAIL cfg_reject_cfg got %h exp %h", dut_cfg, exp_cfg()); end
        end
        th = '{4, 1, 2, 1};
        tv = '{2, 1, 1, 1};
        cfg_h = pk_h(th);
        cfg_v = pk_v(tv);
        tick();
        cfg_valid = 1'b0;
        n_chk++;
        if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL cfg_clear got %b exp 0", cfg_err); end
        for (int i = 0; i < 120; i++) begin
            tick();
            n_chk++;
            if (dut_run !== exp_run()) begin n_fail++; $display("FAIL cfg_run got %h exp %h", dut_run, exp_run()); end
            n_chk++;
            if (dut_cfg !== exp_cfg()) begin n_fail++; $display("FAIL cfg_cfg got %h exp %h", dut_cfg, exp_cfg()); end
        end
    endtask

    task automatic test_drain();
        int fs = 0;
        for (int i = 0; i < 100 && !(cur_h() == 0 && cur_v() == 1); i++) tick();
        enable = 1'b0;
        for (int i = 0; i < 100 && m_run; i++) begin
            tick();
            n_chk++;
            if (dut_run !== exp_run()) begin n_fail++; $display("FAIL drain_run got %h exp %h", dut_run, exp_run()); end
        end
        n_chk++;
        if (m_run || pixel_inc !== 1'b0 || hcount !== '0 || vcount !== '0 || running !== 1'b0) begin
            n_fail++; $display("FAIL drain_idle got inc=%b h=%0d v=%0d run=%b exp 0/0/0/0", pixel_inc, hcount, vcount, running);
        end
        enable = 1'b1;
        for (int i = 0; i < 50; i++) tick();
        enable = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        enable = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            fs += int'(frame_start);
            n_chk++;
            if (dut_run !== exp_run()) begin n_fail++; $display("FAIL rerun_run got %h exp %h", dut_run, exp_run()); end
        end
        n_chk++;
        if (fs !== 1) begin n_fail++; $display("FAIL rerun_fs got %0d exp 1", fs); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 40) == 0) enable = ~enable;
            cfg_valid = 1'b0;
            if ($urandom_range(0, 15) == 0) begin
                th = '{int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2))};
                tv = '{int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), int'($urandom_range(0, 2)), int'($urandom_range(0, 1))};
                cfg_h = pk_h(th);
                cfg_v = pk_v(tv);
                cfg_valid = 1'b1;
            end
            tick();
            n_chk++;
            if (dut_run !== exp_run()) begin n_fail++; $display("FAIL rand_run cyc %0d got %h exp %h", i, dut_run, exp_run()); end
            n_chk++;
            if (dut_cfg !== exp_cfg()) begin n_fail++; $display("FAIL rand_cfg cyc %0d got %h exp %h", i, dut_cfg, exp_cfg()); end
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        th = '{4, 1, 2, 1};
        tv = '{2, 1, 1, 1};
        cfg_h = pk_h(th);
        cfg_v = pk_v(tv);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        tick();
        th = '{6, 1, 1, 2};
        cfg_h = pk_h(th);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        for (int i = 0; i < 60 && !(cur_h() == 5 && cur_v() == 3); i++) tick();
        n_chk++;
        if (!(cur_h() == 5 && cur_v() == 3) || !m_pend) begin
            n_fail++; $display("FAIL arst_wait got h=%0d v=%0d pend=%b exp 5/3/1", cur_h(), cur_v(), m_pend);
        end
        #2 rst = 1'b1;
        #1 model_reset();
        n_chk++;
        if (dut_run !== exp_run()) begin n_fail++; $display("FAIL arst_run got %h exp %h", dut_run, exp_run()); end
        n_chk++;
        if (dut_cfg !== exp_cfg()) begin n_fail++; $display("FAIL arst_cfg got %h exp %h", dut_cfg, exp_cfg()); end
        @(negedge clk);
        enable = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_chk++;
            if (dut_cfg !== exp_cfg()) begin n_fail++; $display("FAIL arst_after_cfg got %h exp %h", dut_cfg, exp_cfg()); end
            n_chk++;
            if (dut_run !== exp_run()) begin n_fail++; $display("FAIL arst_after_run got %h exp %h", dut_run, exp_run()); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_default_run();
        test_small_mode();
        test_mode_change();
        test_cfg_error();
        test_drain();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
